// File: rtl/fpu68881_pin_wrapper_if.sv
// Bus-side signal bundle for the MC68881-style coprocessor pin wrapper.
// The 32-bit data bus D is not part of this bundle; it is a plain inout on the wrapper.
interface fpu68881_pin_wrapper_if;
  logic       SIZE;    // 1 = 32-bit port, 0 = 16-bit port
  logic       SENSE;   // coprocessor present
  logic [4:0] A;       // register address
  logic       AS;      // address strobe, active-high
  logic       R_W;     // 1 = read, 0 = write
  logic       DS;      // data strobe, active-high
  logic       CS;      // chip select, active-high
  logic       DSACK0;  // active-low, alone = 16-bit ack
  logic       DSACK1;  // active-low, alone = 32-bit ack

  modport slave (
    input  SIZE, A, AS, R_W, DS, CS,
    output SENSE, DSACK0, DSACK1
  );

  modport master (
    output SIZE, A, AS, R_W, DS, CS,
    input  SENSE, DSACK0, DSACK1
  );
endinterface

// File: rtl/fpu68881_pin_wrapper.sv
// MC68881-style coprocessor register file (FP0-FP7, FPCR, FPSR, FPIAR) on a
// 68020/030 asynchronous bus with DSACK0/DSACK1 handshake. No arithmetic here.
// Optional: define MC68881_OPCODE_REG_EN to keep fetched opcodes readable at 01011.
module fpu68881_pin_wrapper (
  input  logic                  CLK,
  input  logic                  RESET,
  fpu68881_pin_wrapper_if.slave bus,
  inout  wire [31:0]            D
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT_END = 2'd2} state_t;
  state_t state_reg, state_next;

  logic [79:0] fp_reg [0:7];
  logic [31:0] fpcr_reg, fpsr_reg, fpiar_reg;
`ifdef MC68881_OPCODE_REG_EN
  logic [31:0] opcode_reg;
`endif
  logic [2:0]  sub_cnt_reg, last_phase_reg;
  logic [4:0]  last_a_reg;
  logic        last_rw_reg, ack16_reg, sense_reg, dsack0_reg, dsack1_reg, d_oe_reg;
  logic [31:0] rd_data_reg;

  logic        sel, is_fetch, is_read, is_write, valid, start;
  logic        a_fp, a_ctl, a_op, force_zero, ack16, ack_on, end_now;
  logic [2:0]  phase, n_last;
  logic [31:0] word, rd_data, wr_word;
  logic [79:0] fp_sel;

  // Cycle decode; CS&AS&~DS&~R_W matches none of these and is ignored.
  assign sel      = bus.CS & bus.AS;
  assign is_fetch = sel & ~bus.DS & bus.R_W;
  assign is_read  = sel &  bus.DS & bus.R_W;
  assign is_write = sel &  bus.DS & ~bus.R_W;
  assign valid    = is_fetch | is_read | is_write;
  assign start    = (state_reg == IDLE) & valid;

  assign a_fp  = (bus.A[4:3] == 2'b00);
  assign a_ctl = (bus.A == 5'd8) | (bus.A == 5'd9) | (bus.A == 5'd10);
`ifdef MC68881_OPCODE_REG_EN
  assign a_op  = (bus.A == 5'd11);
`else
  assign a_op  = 1'b0;
`endif

  // A new target or direction (or any fetch) restarts the multi-phase sequence.
  assign force_zero = is_fetch | (bus.A != last_a_reg) | (bus.R_W != last_rw_reg);
  assign phase      = force_zero ? 3'd0 : sub_cnt_reg;
  // Only the sign/exponent phase of a 32-bit FP transfer narrows to a 16-bit ack.
  assign ack16      = ~bus.SIZE | (a_fp & ~is_fetch & (phase == 3'd2));

  // Select the 32-bit control/opcode word addressed by A.
  always_comb begin
    word = 32'd0;
    case (bus.A)
      5'd8:    word = fpcr_reg;
      5'd9:    word = fpsr_reg;
      5'd10:   word = fpiar_reg;
`ifdef MC68881_OPCODE_REG_EN
      5'd11:   word = opcode_reg;
`endif
      default: word = 32'd0;
    endcase
  end

  // Read data for the current phase; upper half is zero on 16-bit transfers.
  always_comb begin
    fp_sel  = fp_reg[bus.A[2:0]];
    rd_data = 32'd0;
    if (a_fp) begin
      if (bus.SIZE) begin
        case (phase)
          3'd0:    rd_data = fp_sel[31:0];
          3'd1:    rd_data = fp_sel[63:32];
          3'd2:    rd_data = {16'd0, fp_sel[79:64]};
          default: rd_data = 32'd0;
        endcase
      end else if (phase <= 3'd4) begin
        rd_data = {16'd0, fp_sel[{phase, 4'b0000} +: 16]};
      end
    end else if (a_ctl | a_op) begin
      if (bus.SIZE)             rd_data = word;
      else if (phase == 3'd0)   rd_data = {16'd0, word[31:16]};
      else if (phase == 3'd1)   rd_data = {16'd0, word[15:0]};
    end
  end

  // Merge halfword writes into a control register, high half first.
  always_comb begin
    wr_word = word;
    if (bus.SIZE)             wr_word = D;
    else if (phase == 3'd0)   wr_word = {D[15:0], word[15:0]};
    else if (phase == 3'd1)   wr_word = {word[31:16], D[15:0]};
  end

  // Index of the last phase for the addressed register at this port width.
  always_comb begin
    n_last = 3'd0;
    if (is_fetch)                        n_last = 3'd0;
    else if (a_fp)                       n_last = bus.SIZE ? 3'd2 : 3'd4;
    else if ((a_ctl | a_op) && !bus.SIZE) n_last = 3'd1;
  end

  // Handshake FSM next-state: ack one edge after acceptance, release after CS/AS drop.
  always_comb begin
    state_next = state_reg;
    ack_on     = 1'b0;
    end_now    = 1'b0;
    case (state_reg)
      IDLE:     if (valid) state_next = ACK;
      ACK: begin
        if (sel) begin
          state_next = WAIT_END;
          ack_on     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_END: begin
        if (!sel) begin
          state_next = IDLE;
          end_now    = 1'b1;
        end
      end
      default:  state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Handshake outputs, read data, and subcycle bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sense_reg      <= 1'b0;
      dsack0_reg     <= 1'b1;
      dsack1_reg     <= 1'b1;
      d_oe_reg       <= 1'b0;
      rd_data_reg    <= 32'd0;
      sub_cnt_reg    <= 3'd0;
      last_phase_reg <= 3'd0;
      last_a_reg     <= 5'd0;
      last_rw_reg    <= 1'b0;
      ack16_reg      <= 1'b0;
    end else begin
      sense_reg <= 1'b1;
      d_oe_reg  <= is_read;
      if (start) begin
        rd_data_reg    <= rd_data;
        sub_cnt_reg    <= phase;
        last_phase_reg <= n_last;
        last_a_reg     <= bus.A;
        last_rw_reg    <= bus.R_W;
        ack16_reg      <= ack16;
      end
      if (ack_on) begin
        dsack0_reg <= ~ack16_reg;
        dsack1_reg <= ack16_reg;
      end else if (state_next == IDLE) begin
        dsack0_reg <= 1'b1;
        dsack1_reg <= 1'b1;
      end
      if (end_now)
        sub_cnt_reg <= (sub_cnt_reg >= last_phase_reg) ? 3'd0 : sub_cnt_reg + 3'd1;
    end
  end

  // Register file: writes and opcode capture commit at the accepting edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 8; i++) fp_reg[i] <= 80'd0;
      fpcr_reg  <= 32'd0;
      fpsr_reg  <= 32'd0;
      fpiar_reg <= 32'd0;
`ifdef MC68881_OPCODE_REG_EN
      opcode_reg <= 32'd0;
`endif
    end else if (start && is_write) begin
      if (a_fp) begin
        if (bus.SIZE) begin
          case (phase)
            3'd0:    fp_reg[bus.A[2:0]][31:0]  <= D;
            3'd1:    fp_reg[bus.A[2:0]][63:32] <= D;
            3'd2:    fp_reg[bus.A[2:0]][79:64] <= D[15:0];
            default: ;
          endcase
        end else if (phase <= 3'd4) begin
          fp_reg[bus.A[2:0]][{phase, 4'b0000} +: 16] <= D[15:0];
        end
      end else begin
        case (bus.A)
          5'd8:    fpcr_reg  <= wr_word;
          5'd9:    fpsr_reg  <= wr_word;
          5'd10:   fpiar_reg <= wr_word;
          default: ;
        endcase
      end
    end
`ifdef MC68881_OPCODE_REG_EN
    else if (start && is_fetch) begin
      opcode_reg <= bus.SIZE ? D : {16'd0, D[15:0]};
    end
`endif
  end

  assign bus.SENSE  = sense_reg;
  assign bus.DSACK0 = dsack0_reg;
  assign bus.DSACK1 = dsack1_reg;
  assign D          = d_oe_reg ? rd_data_reg : 32'bz;
endmodule

// File: tb/tb_fpu68881_pin_wrapper.sv
// Directed bench for fpu68881_pin_wrapper: expected acks/data go into a queue as each
// bus cycle is driven and are popped and compared once the wrapper acknowledges.
// A pullup on D makes a released bus read back as all ones.
module tb_fpu68881_pin_wrapper;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire  [31:0] d_bus;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_d = 32'd0;
  int          compared = 0;
  int          mismatched = 0;

  typedef struct {
    string       tag;
    logic [1:0]  ack;
    logic [31:0] data;
    logic        chk;
  } exp_t;
  exp_t sb[$];

  // {DSACK1, DSACK0}
  localparam logic [1:0] ACK32 = 2'b01;
  localparam logic [1:0] ACK16 = 2'b10;
  localparam logic [1:0] NOACK = 2'b11;
  localparam logic [31:0] DZ   = 32'hFFFF_FFFF;
`ifdef MC68881_OPCODE_REG_EN
  localparam logic [31:0] OPC_EXP = 32'hCAFE_BABE;
`else
  localparam logic [31:0] OPC_EXP = 32'h0000_0000;
`endif

  fpu68881_pin_wrapper_if bus_if();

  fpu68881_pin_wrapper dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_if.slave),
    .D     (d_bus)
  );

  assign d_bus = tb_oe ? tb_d : 32'bz;
  pullup (d_bus);

  always #5 clk = ~clk;

  function automatic logic [31:0] ack_now();
    return {30'd0, bus_if.DSACK1, bus_if.DSACK0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete bus cycle: push expectation, drive, wait for ack (bounded), compare, release.
  task automatic xfer(input string tag, input logic rw, input logic ds, input logic [4:0] a,
                      input logic sz, input logic [31:0] wdata,
                      input logic [1:0] ack, input logic [31:0] data);
    exp_t e;
    exp_t got;
    int   n;
    e.tag  = tag;
    e.ack  = ack;
    e.data = data;
    e.chk  = rw & ds;
    sb.push_back(e);
    bus_if.A    = a;
    bus_if.R_W  = rw;
    bus_if.DS   = ds;
    bus_if.SIZE = sz;
    bus_if.CS   = 1'b1;
    bus_if.AS   = 1'b1;
    tb_d        = wdata;
    tb_oe       = ~(rw & ds);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_now() == {30'd0, NOACK} && n < 8);
    got = sb.pop_front();
    check({got.tag, "_lat"}, 32'(n), 32'd2);
    check({got.tag, "_ack"}, ack_now(), {30'd0, got.ack});
    if (got.chk) check({got.tag, "_data"}, d_bus, got.data);
    $display("xfer %s a=%h rw=%b ds=%b size=%b ack=%b d=%h", got.tag, a, rw, ds, sz,
             ack_now() & 32'h3, d_bus);
    bus_if.CS = 1'b0;
    bus_if.AS = 1'b0;
    bus_if.DS = 1'b0;
    tb_oe     = 1'b0;
    @(negedge clk);
    check({got.tag, "_rel"}, ack_now(), {30'd0, NOACK});
    check({got.tag, "_dz"}, d_bus, DZ);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.A = 5'd0; bus_if.R_W = 1'b0; bus_if.DS = 1'b0;
    bus_if.SIZE = 1'b1; bus_if.CS = 1'b0; bus_if.AS = 1'b0;

    // Reset for two clocks.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sense", {31'd0, bus_if.SENSE}, 32'd0);
    check("rst_ack", ack_now(), {30'd0, NOACK});
    check("rst_dz", d_bus, DZ);
    rst_n = 1'b1;
    @(negedge clk);
    check("sense_up", {31'd0, bus_if.SENSE}, 32'd1);

    // Fetch, then opcode readback.
    xfer("fetch",   1'b1, 1'b0, 5'd0,  1'b1, 32'hCAFE_BABE, ACK32, 32'd0);
    xfer("opc_rd",  1'b1, 1'b1, 5'd11, 1'b1, 32'd0, ACK32, OPC_EXP);

    // FPCR 32-bit write/read.
    xfer("fpcr_wr", 1'b0, 1'b1, 5'd8, 1'b1, 32'hA5A5_A5A5, ACK32, 32'd0);
    xfer("fpcr_rd", 1'b1, 1'b1, 5'd8, 1'b1, 32'd0, ACK32, 32'hA5A5_A5A5);

    // FP0 three-phase write and read.
    xfer("fp0_w0",  1'b0, 1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF, ACK32, 32'd0);
    xfer("fp0_w1",  1'b0, 1'b1, 5'd0, 1'b1, 32'hCAFE_BABE, ACK32, 32'd0);
    xfer("fp0_w2",  1'b0, 1'b1, 5'd0, 1'b1, 32'h0000_1234, ACK16, 32'd0);
    xfer("fp0_r0",  1'b1, 1'b1, 5'd0, 1'b1, 32'd0, ACK32, 32'hDEAD_BEEF);
    xfer("fp0_r1",  1'b1, 1'b1, 5'd0, 1'b1, 32'd0, ACK32, 32'hCAFE_BABE);
    xfer("fp0_r2",  1'b1, 1'b1, 5'd0, 1'b1, 32'd0, ACK16, 32'h0000_1234);

    // Counter restart: an FPCR access between FP0 writes sends the next FP0 write to phase 0.
    xfer("cr_w0",   1'b0, 1'b1, 5'd0, 1'b1, 32'h1111_1111, ACK32, 32'd0);
    xfer("cr_fpcr", 1'b1, 1'b1, 5'd8, 1'b1, 32'd0, ACK32, 32'hA5A5_A5A5);
    xfer("cr_w0b",  1'b0, 1'b1, 5'd0, 1'b1, 32'h2222_2222, ACK32, 32'd0);
    xfer("cr_r0",   1'b1, 1'b1, 5'd0, 1'b1, 32'd0, ACK32, 32'h2222_2222);
    xfer("cr_r1",   1'b1, 1'b1, 5'd0, 1'b1, 32'd0, ACK32, 32'hCAFE_BABE);
    xfer("cr_r2",   1'b1, 1'b1, 5'd0, 1'b1, 32'd0, ACK16, 32'h0000_1234);

    // 16-bit port: control registers as two halfwords, high half first.
    xfer("fpcr_h",  1'b1, 1'b1, 5'd8, 1'b0, 32'd0, ACK16, 32'h0000_A5A5);
    xfer("fpcr_l",  1'b1, 1'b1, 5'd8, 1'b0, 32'd0, ACK16, 32'h0000_A5A5);
    xfer("fpsr_wr", 1'b0, 1'b1, 5'd9, 1'b1, 32'h1234_5678, ACK32, 32'd0);
    xfer("fpsr_h",  1'b1, 1'b1, 5'd9, 1'b0, 32'd0, ACK16, 32'h0000_1234);
    xfer("fpsr_l",  1'b1, 1'b1, 5'd9, 1'b0, 32'd0, ACK16, 32'h0000_5678);

    // 16-bit port: FP3 written as five halfwords, least significant first, read back 32-bit.
    for (int i = 0; i < 5; i++)
      xfer($sformatf("fp3_h%0d", i), 1'b0, 1'b1, 5'd3, 1'b0, 32'hFFFF_0000 | (32'h1111 * (i + 1)),
           ACK16, 32'd0);
    xfer("fp3_r0",  1'b1, 1'b1, 5'd3, 1'b1, 32'd0, ACK32, 32'h2222_1111);
    xfer("fp3_r1",  1'b1, 1'b1, 5'd3, 1'b1, 32'd0, ACK32, 32'h4444_3333);
    xfer("fp3_r2",  1'b1, 1'b1, 5'd3, 1'b1, 32'd0, ACK16, 32'h0000_5555);

    // Reserved address: acknowledged, write dropped, reads zero.
    xfer("rsv_wr",  1'b0, 1'b1, 5'd31, 1'b1, 32'h1234_5678, ACK32, 32'd0);
    xfer("rsv_rd",  1'b1, 1'b1, 5'd31, 1'b1, 32'd0, ACK32, 32'd0);

    // Ignored cycle type (~DS & ~R_W): never acknowledged.
    bus_if.A = 5'd8; bus_if.R_W = 1'b0; bus_if.DS = 1'b0; bus_if.SIZE = 1'b1;
    bus_if.CS = 1'b1; bus_if.AS = 1'b1; tb_oe = 1'b1; tb_d = 32'h0;
    repeat (4) @(negedge clk);
    check("ign_noack", ack_now(), {30'd0, NOACK});
    $display("xfer ign a=%h ack=%b", bus_if.A, ack_now() & 32'h3);
    bus_if.CS = 1'b0; bus_if.AS = 1'b0; tb_oe = 1'b0;
    @(negedge clk);

    // CS/AS drop before ack: no ack, but the write to FPIAR stays committed.
    bus_if.A = 5'd10; bus_if.R_W = 1'b0; bus_if.DS = 1'b1;
    bus_if.CS = 1'b1; bus_if.AS = 1'b1; tb_oe = 1'b1; tb_d = 32'h0BAD_F00D;
    @(negedge clk);
    bus_if.CS = 1'b0; bus_if.AS = 1'b0; bus_if.DS = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
    check("abort_noack", ack_now(), {30'd0, NOACK});
    $display("xfer abort a=%h ack=%b", bus_if.A, ack_now() & 32'h3);
    @(negedge clk);
    xfer("abort_rd", 1'b1, 1'b1, 5'd10, 1'b1, 32'd0, ACK32, 32'h0BAD_F00D);

    // Reset in the middle of an acknowledged read.
    bus_if.A = 5'd8; bus_if.R_W = 1'b1; bus_if.DS = 1'b1; bus_if.SIZE = 1'b1;
    bus_if.CS = 1'b1; bus_if.AS = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_ack", ack_now(), {30'd0, ACK32});
    check("mid_data", d_bus, 32'hA5A5_A5A5);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ack", ack_now(), {30'd0, NOACK});
    check("mid_rst_sense", {31'd0, bus_if.SENSE}, 32'd0);
    check("mid_rst_dz", d_bus, DZ);
    $display("xfer midrst a=%h ack=%b d=%h", bus_if.A, ack_now() & 32'h3, d_bus);
    bus_if.CS = 1'b0; bus_if.AS = 1'b0; bus_if.DS = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    xfer("post_fpcr", 1'b1, 1'b1, 5'd8, 1'b1, 32'd0, ACK32, 32'd0);
    xfer("post_fp0",  1'b1, 1'b1, 5'd0, 1'b1, 32'd0, ACK32, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
